// File: rtl/tag_sched_pkg.sv
// Shared definitions for the tag hazard scheduler.
//   - sched_state_t : scheduler FSM encoding (RUN, STALL, FLUSH)
//   - lowest_set    : priority encoder returning the index of the lowest
//                     set bit (stage 0 is the newest, so this picks the
//                     youngest producer of a tag)
package tag_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_t;

  // Callers zero-extend their NUM_STAGES-wide hit vector to 32 bits and
  // truncate the result to their stage-index width. Scanning from the top
  // down lets the lowest set bit overwrite any higher one.
  function automatic int lowest_set(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int k = 31; k >= 0; k--) begin
      if (vec[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/tag_hazard_check.sv
// Combinational per-source hazard / forwarding decision.
// Ports:
//   found      in  NUM_SRC                 shift register hit per source
//   src_valid  in  NUM_SRC                 source operand is used
//   index      in  NUM_SRC x NUM_STAGES    per-stage hit vector per source
//   fwd_valid  out NUM_SRC                 source forwarded from fwd_stage
//   fwd_stage  out NUM_SRC x STG_W         newest producing stage
//   haz        out NUM_SRC                 producer too young to forward
module tag_hazard_check
  import tag_sched_pkg::*;
#(
  parameter int NUM_SRC       = 3,
  parameter int NUM_STAGES    = 3,
  parameter int FWD_MIN_STAGE = 1,
  localparam int STG_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic [NUM_SRC-1:0]                 found,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC-1:0][NUM_STAGES-1:0] index,
  output logic [NUM_SRC-1:0]                 fwd_valid,
  output logic [NUM_SRC-1:0][STG_W-1:0]      fwd_stage,
  output logic [NUM_SRC-1:0]                 haz
);

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic             hit;
      logic [STG_W-1:0] stage;
      logic             young;

      // An unused source is masked entirely: no forward, no hazard.
      assign hit   = found[gi] & src_valid[gi];
      assign stage = STG_W'(lowest_set(32'(index[gi])));
      assign young = (32'(stage) < 32'(FWD_MIN_STAGE));

      assign fwd_stage[gi] = stage;
      assign fwd_valid[gi] = hit & ~young;
      assign haz[gi]       = hit & young;
    end
  endgenerate

endmodule

// File: rtl/tag_hazard_sched.sv
// Issue-side controller for the in-flight destination tag shift register.
// Tests the waiting instruction's sources against in-flight tags, picks a
// forwarding stage per source, stalls on producers too young to forward
// from, and drains the shift register with bubbles on flush.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   issue_valid/dest/dest_valid     instruction waiting to issue
//   issue_src/issue_src_valid       its source tags and use flags
//   pipe_advance                    downstream pipeline moves this cycle
//   flush                           discard all in-flight work (pulse)
//   issue_ready                     instruction accepted this cycle
//   fwd_valid/fwd_stage             forwarding selection per source
//   stalled, stall_cnt              STALL state flag, saturating stall count
//   sr_shift/sr_tag/sr_tag_valid    shift register write side
//   sr_test/sr_found/sr_index       shift register test ports
module tag_hazard_sched
  import tag_sched_pkg::*;
#(
  parameter int TAG_SIZE      = 5,
  parameter int NUM_STAGES    = 3,
  parameter int NUM_SRC       = 3,
  parameter int FWD_MIN_STAGE = 1,
  parameter int STALL_CNT_W   = 16,
  localparam int STG_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int DRAIN_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               issue_valid,
  input  logic [TAG_SIZE-1:0]                issue_dest,
  input  logic                               issue_dest_valid,
  input  logic [NUM_SRC-1:0][TAG_SIZE-1:0]   issue_src,
  input  logic [NUM_SRC-1:0]                 issue_src_valid,
  input  logic                               pipe_advance,
  input  logic                               flush,
  output logic                               issue_ready,
  output logic [NUM_SRC-1:0]                 fwd_valid,
  output logic [NUM_SRC-1:0][STG_W-1:0]      fwd_stage,
  output logic                               stalled,
  output logic [STALL_CNT_W-1:0]             stall_cnt,
  output logic                               sr_shift,
  output logic [TAG_SIZE-1:0]                sr_tag,
  output logic                               sr_tag_valid,
  output logic [NUM_SRC-1:0][TAG_SIZE-1:0]   sr_test,
  input  logic [NUM_SRC-1:0]                 sr_found,
  input  logic [NUM_SRC-1:0][NUM_STAGES-1:0] sr_index
);

  sched_state_t             state_reg, state_next;
  logic [DRAIN_W-1:0]       drain_reg, drain_next;
  logic [STALL_CNT_W-1:0]   stall_cnt_reg;

  logic [NUM_SRC-1:0]       fwd_raw;
  logic [NUM_SRC-1:0]       haz;
  logic                     hazard;
  logic                     fwd_en;

  // The new tag shifts in after the test, so a source equal to the
  // instruction's own destination only ever sees older entries.
  assign sr_test = issue_src;
  assign sr_tag  = issue_dest;

  tag_hazard_check #(
    .NUM_SRC       (NUM_SRC),
    .NUM_STAGES    (NUM_STAGES),
    .FWD_MIN_STAGE (FWD_MIN_STAGE)
  ) u_check (
    .found     (sr_found),
    .src_valid (issue_src_valid),
    .index     (sr_index),
    .fwd_valid (fwd_raw),
    .fwd_stage (fwd_stage),
    .haz       (haz)
  );

  assign hazard = |haz;

  always_comb begin
    state_next   = state_reg;
    drain_next   = drain_reg;
    sr_shift     = 1'b0;
    sr_tag_valid = 1'b0;
    issue_ready  = 1'b0;
    fwd_en       = 1'b0;

    if (!reset) begin
      case (state_reg)
        ST_FLUSH: begin
          sr_shift   = 1'b1;
          drain_next = (drain_reg != '0) ? drain_reg - 1'b1 : '0;
          // Leaving at count 1 gives exactly NUM_STAGES bubble shifts.
          if (drain_reg <= DRAIN_W'(1)) state_next = ST_RUN;
        end
        default: begin
          fwd_en       = 1'b1;
          sr_shift     = pipe_advance;
          issue_ready  = issue_valid & pipe_advance & ~hazard & ~flush;
          sr_tag_valid = issue_ready & issue_dest_valid;
          // Without a pipeline move nothing changes, including the state.
          if (pipe_advance) begin
            state_next = (issue_valid & hazard) ? ST_STALL : ST_RUN;
          end
        end
      endcase

      // Flush wins over everything and restarts a drain already underway.
      if (flush) begin
        state_next = ST_FLUSH;
        drain_next = DRAIN_W'(NUM_STAGES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      drain_reg     <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      if (state_reg == ST_STALL && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign fwd_valid = fwd_en ? fwd_raw : '0;
  assign stalled   = (state_reg == ST_STALL) & ~reset;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_tag_hazard_sched.sv
// Integration bench: tag_hazard_sched driving a behavioural tag shift
// register (stage 0 newest). Table-driven single-cycle vectors followed by
// hand-written multi-cycle sequences (saturation, reset mid-STALL/FLUSH).
module tb_tag_hazard_sched;

  localparam int TS   = 5;
  localparam int NS   = 3;
  localparam int NSRC = 3;
  localparam int SW   = 2;
  localparam int CW   = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       issue_valid;
  logic [TS-1:0]              issue_dest;
  logic                       issue_dest_valid;
  logic [NSRC-1:0][TS-1:0]    issue_src;
  logic [NSRC-1:0]            issue_src_valid;
  logic                       pipe_advance;
  logic                       flush;
  logic                       issue_ready;
  logic [NSRC-1:0]            fwd_valid;
  logic [NSRC-1:0][SW-1:0]    fwd_stage;
  logic                       stalled;
  logic [CW-1:0]              stall_cnt;
  logic                       sr_shift;
  logic [TS-1:0]              sr_tag;
  logic                       sr_tag_valid;
  logic [NSRC-1:0][TS-1:0]    sr_test;
  logic [NSRC-1:0]            sr_found;
  logic [NSRC-1:0][NS-1:0]    sr_index;

  always #5 clk = ~clk;

  tag_hazard_sched dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_dest       (issue_dest),
    .issue_dest_valid (issue_dest_valid),
    .issue_src        (issue_src),
    .issue_src_valid  (issue_src_valid),
    .pipe_advance     (pipe_advance),
    .flush            (flush),
    .issue_ready      (issue_ready),
    .fwd_valid        (fwd_valid),
    .fwd_stage        (fwd_stage),
    .stalled          (stalled),
    .stall_cnt        (stall_cnt),
    .sr_shift         (sr_shift),
    .sr_tag           (sr_tag),
    .sr_tag_valid     (sr_tag_valid),
    .sr_test          (sr_test),
    .sr_found         (sr_found),
    .sr_index         (sr_index)
  );

  // Behavioural tag shift register: combinational test, registered shift.
  logic [NS-1:0][TS-1:0] sr_tags;
  logic [NS-1:0]         sr_vals;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_vals <= '0;
      sr_tags <= '0;
    end else if (sr_shift) begin
      sr_tags <= {sr_tags[NS-2:0], sr_tag};
      sr_vals <= {sr_vals[NS-2:0], sr_tag_valid};
    end
  end

  always_comb begin
    sr_index = '0;
    sr_found = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int s = 0; s < NS; s++) begin
        sr_index[i][s] = sr_vals[s] && (sr_tags[s] == sr_test[i]);
      end
      sr_found[i] = |sr_index[i];
    end
  end

  typedef struct packed {
    logic                    rst;
    logic                    iv;
    logic [TS-1:0]           dest;
    logic                    dv;
    logic [NSRC-1:0][TS-1:0] src;
    logic [NSRC-1:0]         sv;
    logic                    pa;
    logic                    fl;
    logic                    rdy;
    logic [NSRC-1:0]         fv;
    logic [NSRC-1:0][SW-1:0] fs;
    logic                    stl;
    logic                    sh;
    logic                    tv;
    logic [CW-1:0]           cnt;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(int rst, int iv, int dest, int dv,
                              int s0, int s1, int s2, int sv, int pa, int fl,
                              int rdy, int fv, int f0, int f1, int f2,
                              int stl, int sh, int tv, int cnt);
    vec_t v;
    v.rst = 1'(rst);   v.iv = 1'(iv);   v.dest = TS'(dest); v.dv = 1'(dv);
    v.src[0] = TS'(s0); v.src[1] = TS'(s1); v.src[2] = TS'(s2);
    v.sv = NSRC'(sv);  v.pa = 1'(pa);   v.fl = 1'(fl);
    v.rdy = 1'(rdy);   v.fv = NSRC'(fv);
    v.fs[0] = SW'(f0); v.fs[1] = SW'(f1); v.fs[2] = SW'(f2);
    v.stl = 1'(stl);   v.sh = 1'(sh);   v.tv = 1'(tv);  v.cnt = CW'(cnt);
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    reset            = v.rst;
    issue_valid      = v.iv;
    issue_dest       = v.dest;
    issue_dest_valid = v.dv;
    issue_src        = v.src;
    issue_src_valid  = v.sv;
    pipe_advance     = v.pa;
    flush            = v.fl;
  endtask

  task automatic set_in(input logic rst, input logic iv, input int dest,
                        input int s0, input int sv, input logic pa, input logic fl);
    reset            = rst;
    issue_valid      = iv;
    issue_dest       = TS'(dest);
    issue_dest_valid = 1'b1;
    issue_src        = '0;
    issue_src[0]     = TS'(s0);
    issue_src_valid  = NSRC'(sv);
    pipe_advance     = pa;
    flush            = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst iv dst dv  s0 s1 s2 sv pa fl  rdy fv f0 f1 f2 stl sh tv cnt
    add(1, 1,  5, 1,  5, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0); // reset forces outputs
    add(0, 1,  5, 1,  0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 0); // issue dest 5
    add(0, 1,  9, 1,  5, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0); // 5 at stage 0: hazard
    add(0, 1,  9, 1,  5, 0, 0, 1, 1, 0,  1, 1, 1, 0, 0, 1, 1, 1, 0); // stalled, fwd from 1
    add(0, 1,  7, 1,  0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1); // stall_cnt now 1
    add(0, 1, 10, 1, 20, 0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1); // unrelated
    add(0, 1, 11, 0,  0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0, 1); // no dest write
    add(0, 1, 12, 1,  0, 7, 0, 2, 1, 0,  1, 2, 0, 2, 0, 0, 1, 1, 1); // src1=7 from stage 2
    add(0, 1,  3, 1,  0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1); // dest 3
    add(0, 1,  3, 1,  0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1); // dest 3 again
    add(0, 1, 13, 1,  0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1); // dest 13
    add(0, 1, 14, 1,  3, 0,13, 1, 1, 0,  1, 1, 1, 0, 0, 0, 1, 1, 1); // newest 3, src2 masked
    add(0, 1, 21, 1,  0,21, 0, 2, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1); // src == own dest
    for (int k = 0; k < 4; k++)
      add(0, 1, 22, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1); // no advance
    add(0, 1, 22, 1, 21, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1); // hazard, held RUN
    add(0, 1, 22, 1, 14, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 1); // fwd w/o advance
    add(0, 1, 22, 1,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1); // flush, no advance
    for (int k = 0; k < 3; k++)
      add(0, 1, 23, 1, 14, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 1); // FLUSH drain
    add(0, 1, 23, 1, 21,14,13, 7, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1); // old tags gone
    add(0, 1, 24, 1,  0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0, 1); // flush w/ advance
    add(0, 1, 24, 1,  0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 1); // FLUSH
    add(0, 1, 24, 1,  0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0, 1); // flush restarts drain
    for (int k = 0; k < 3; k++)
      add(0, 1, 24, 1,  0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 1); // FLUSH
    add(0, 1, 24, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1); // back in RUN

    // One clean reset cycle so the table starts from known state.
    set_in(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    next_cycle();

    for (int n = 0; n < vq.size(); n++) begin
      vec_t v;
      v = vq[n];
      drive(v);
      @(negedge clk);
      $display("vec %0d: rdy=%0b fv=%b fs=%h stl=%0b sh=%0b tv=%0b cnt=%0d",
               n, issue_ready, fwd_valid, fwd_stage, stalled, sr_shift, sr_tag_valid, stall_cnt);
      chk($sformatf("vec%0d issue_ready", n), 32'(issue_ready), 32'(v.rdy));
      chk($sformatf("vec%0d fwd_valid", n), 32'(fwd_valid), 32'(v.fv));
      for (int i = 0; i < NSRC; i++)
        if (v.fv[i]) chk($sformatf("vec%0d fwd_stage%0d", n, i), 32'(fwd_stage[i]), 32'(v.fs[i]));
      chk($sformatf("vec%0d stalled", n), 32'(stalled), 32'(v.stl));
      chk($sformatf("vec%0d sr_shift", n), 32'(sr_shift), 32'(v.sh));
      chk($sformatf("vec%0d sr_tag_valid", n), 32'(sr_tag_valid), 32'(v.tv));
      chk($sformatf("vec%0d stall_cnt", n), 32'(stall_cnt), 32'(v.cnt));
      next_cycle();
    end

    // Saturation: enter STALL, then hold it with pipe_advance=0.
    set_in(1'b0, 1'b1, 5, 0, 0, 1'b1, 1'b0);   // issue dest 5
    next_cycle();
    set_in(1'b0, 1'b1, 9, 5, 1, 1'b1, 1'b0);   // hazard -> STALL
    next_cycle();
    set_in(1'b0, 1'b1, 9, 5, 1, 1'b0, 1'b0);   // hold STALL
    repeat (65533) @(posedge clk);             // count starts at 1
    #1;
    $display("sat: stalled=%0b cnt=%0h", stalled, stall_cnt);
    chk("sat stalled", 32'(stalled), 32'd1);
    chk("sat cnt near", 32'(stall_cnt), 32'hFFFE);
    repeat (5) @(posedge clk);
    #1;
    $display("sat: stalled=%0b cnt=%0h", stalled, stall_cnt);
    chk("sat cnt hold", 32'(stall_cnt), 32'hFFFF);

    // Reset during STALL.
    set_in(1'b1, 1'b1, 9, 5, 1, 1'b1, 1'b0);
    @(negedge clk);
    $display("rst in stall: rdy=%0b sh=%0b stl=%0b", issue_ready, sr_shift, stalled);
    chk("rst stall stalled", 32'(stalled), 32'd0);
    chk("rst stall ready", 32'(issue_ready), 32'd0);
    chk("rst stall shift", 32'(sr_shift), 32'd0);
    chk("rst stall tag_valid", 32'(sr_tag_valid), 32'd0);
    next_cycle();
    set_in(1'b0, 1'b1, 9, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    $display("after rst: stl=%0b cnt=%0h", stalled, stall_cnt);
    chk("post rst stalled", 32'(stalled), 32'd0);
    chk("post rst cnt", 32'(stall_cnt), 32'd0);
    next_cycle();

    // Reset during FLUSH.
    set_in(1'b0, 1'b1, 9, 0, 0, 1'b0, 1'b1);   // flush pulse
    next_cycle();
    set_in(1'b0, 1'b1, 9, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush before rst shift", 32'(sr_shift), 32'd1);
    next_cycle();
    set_in(1'b1, 1'b1, 9, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    $display("rst in flush: sh=%0b tv=%0b rdy=%0b", sr_shift, sr_tag_valid, issue_ready);
    chk("rst flush shift", 32'(sr_shift), 32'd0);
    chk("rst flush ready", 32'(issue_ready), 32'd0);
    next_cycle();
    set_in(1'b0, 1'b1, 9, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    $display("after rst: sh=%0b stl=%0b", sr_shift, stalled);
    chk("post flush rst shift", 32'(sr_shift), 32'd0);
    chk("post flush rst stalled", 32'(stalled), 32'd0);
    set_in(1'b0, 1'b1, 9, 0, 0, 1'b1, 1'b0);
    #1;
    chk("post flush rst ready", 32'(issue_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
